// File: rtl/imm_gen_pipe.sv
// Immediate generator for the decode stage: decodes a RISC-V instruction word
// into a sign-extended immediate, format code and illegal flag, held in a
// registered output stage with a one-entry skid buffer.
module imm_gen_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter bit          ENABLE_UJ = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t      state;
  entry_t      o_q;
  entry_t      k_q;
  entry_t      dec;
  logic [31:0] imm32;
  logic [2:0]  funct3;
  logic        in_fire;
  logic        out_fire;

  assign funct3 = in_instr[14:12];

  // Combinational decode; imm32 is the 32-bit sign-correct value, widened below.
  // Shift amounts have bit 31 clear, so sign-extending them is a zero-extend.
  always_comb begin
    imm32       = 32'd0;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    case (in_instr[6:0])
      OP_LOAD: begin
        dec.fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_IMM: begin
        dec.fmt = FMT_I;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          imm32 = (XLEN == 64) ? {26'd0, in_instr[25:20]} : {27'd0, in_instr[24:20]};
        end else begin
          imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_JALR: begin
        if (ENABLE_UJ) begin
          dec.fmt = FMT_I;
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_LUI, OP_AUIPC: begin
        if (ENABLE_UJ) begin
          dec.fmt = FMT_U;
          imm32   = {in_instr[31:12], 12'd0};
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_JAL: begin
        if (ENABLE_UJ) begin
          dec.fmt = FMT_J;
          imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_OP: begin
        dec.fmt = FMT_NONE;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    dec.imm = XLEN'($signed(imm32));
  end

  assign in_ready  = (state != TWO) && !rst;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state != EMPTY);
  assign out_fire  = out_valid && out_ready;

  // Output/skid occupancy and data; rst beats flush, flush beats handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      o_q   <= '0;
      k_q   <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            o_q   <= dec;
            state <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            o_q <= dec;
          end else if (in_fire) begin
            k_q   <= dec;
            state <= TWO;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            o_q   <= k_q;
            state <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  assign out_imm     = o_q.imm;
  assign out_fmt     = o_q.fmt;
  assign out_illegal = o_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (RV32, RV64, RV32 without U/J)
// share stimulus and are checked against a queue model every cycle.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;

  logic        rdy32, rdy64, rdyn;
  logic        v32, v64, vn;
  logic [31:0] imm32, immn;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64, fmtn;
  logic        ill32, ill64, illn;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .ENABLE_UJ(1'b1)) u_d32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32));

  imm_gen_pipe #(.XLEN(64), .ENABLE_UJ(1'b1)) u_d64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64));

  imm_gen_pipe #(.XLEN(32), .ENABLE_UJ(1'b0)) u_dn (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdyn),
    .in_instr(in_instr), .out_valid(vn), .out_ready(out_ready),
    .out_imm(immn), .out_fmt(fmtn), .out_illegal(illn));

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } res_t;

  // Reference decode: assemble each field as an unsigned number, then apply
  // the two's-complement weight of the sign bit arithmetically.
  function automatic res_t ref_dec(input logic [31:0] w, input int xlen, input bit uj);
    res_t        r;
    longint      v;
    logic [6:0]  op;
    logic [2:0]  f3;
    op = w[6:0];
    f3 = w[14:12];
    r  = '0;
    v  = 0;
    case (op)
      7'b0000011, 7'b1100111: begin
        if (op == 7'b1100111 && !uj) r.ill = 1'b1;
        else begin
          r.fmt = 3'd1;
          v = longint'(w[31:20]);
          if (w[31]) v = v - 4096;
        end
      end
      7'b0010011: begin
        r.fmt = 3'd1;
        if (f3 == 3'd1 || f3 == 3'd5) v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
        else begin
          v = longint'(w[31:20]);
          if (w[31]) v = v - 4096;
        end
      end
      7'b0100011: begin
        r.fmt = 3'd2;
        v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
        if (w[31]) v = v - 4096;
      end
      7'b1100011: begin
        r.fmt = 3'd3;
        v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        if (w[31]) v = v - 4096;
      end
      7'b0110111, 7'b0010111: begin
        if (!uj) r.ill = 1'b1;
        else begin
          r.fmt = 3'd4;
          v = longint'(w[31:12]) * 4096;
          if (w[31]) v = v - 64'sh1_0000_0000;
        end
      end
      7'b1101111: begin
        if (!uj) r.ill = 1'b1;
        else begin
          r.fmt = 3'd5;
          v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
          if (w[31]) v = v - 1048576;
        end
      end
      7'b0110011: r.fmt = 3'd0;
      default:    r.ill = 1'b1;
    endcase
    r.imm = 64'(v);
    return r;
  endfunction

  // Model: ordered queue of accepted instruction words, capacity two.
  logic [31:0] q[$];
  bit          zexp = 1'b0;

  always @(posedge clk) begin
    bit acc;
    acc = (q.size() < 2) && !rst;
    if (rst) begin
      q.delete();
      zexp = 1'b1;
    end else if (flush) begin
      q.delete();
      zexp = 1'b0;
    end else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && acc) begin
        q.push_back(in_instr);
        zexp = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    res_t  r;
    logic  rdy_exp;
    rdy_exp = (q.size() < 2) && !rst;
    chk("in_ready32", 64'(rdy32), 64'(rdy_exp));
    chk("in_ready64", 64'(rdy64), 64'(rdy_exp));
    chk("in_readyn",  64'(rdyn),  64'(rdy_exp));
    chk("out_valid32", 64'(v32), 64'(q.size() > 0));
    chk("out_valid64", 64'(v64), 64'(q.size() > 0));
    chk("out_validn",  64'(vn),  64'(q.size() > 0));
    if (q.size() > 0) begin
      r = ref_dec(q[0], 32, 1'b1);
      chk("imm32", 64'(imm32), 64'(r.imm[31:0]));
      chk("fmt32", 64'(fmt32), 64'(r.fmt));
      chk("ill32", 64'(ill32), 64'(r.ill));
      r = ref_dec(q[0], 64, 1'b1);
      chk("imm64", imm64, r.imm);
      chk("fmt64", 64'(fmt64), 64'(r.fmt));
      chk("ill64", 64'(ill64), 64'(r.ill));
      r = ref_dec(q[0], 32, 1'b0);
      chk("immn", 64'(immn), 64'(r.imm[31:0]));
      chk("fmtn", 64'(fmtn), 64'(r.fmt));
      chk("illn", 64'(illn), 64'(r.ill));
    end else if (zexp) begin
      chk("rst_imm32", 64'(imm32), 64'd0);
      chk("rst_imm64", imm64, 64'd0);
      chk("rst_fmt", 64'(fmt32), 64'd0);
      chk("rst_ill", 64'(ill32), 64'd0);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
  endtask

  // Hand-computed expectations: word, RV32 imm, RV64 imm, fmt, illegal, illegal without U/J.
  localparam int NLIT = 7;
  logic [31:0] lw_word [NLIT] = '{32'hFFC12083, 32'h00512423, 32'hFE000EE3, 32'h4030D093,
                                  32'h123450B7, 32'h800000B7, 32'h0000007F};
  logic [31:0] lw_i32  [NLIT] = '{32'hFFFFFFFC, 32'h00000008, 32'hFFFFFFFC, 32'h00000003,
                                  32'h12345000, 32'h80000000, 32'h00000000};
  logic [63:0] lw_i64  [NLIT] = '{64'hFFFFFFFFFFFFFFFC, 64'h8, 64'hFFFFFFFFFFFFFFFC, 64'h3,
                                  64'h12345000, 64'hFFFFFFFF80000000, 64'h0};
  logic [2:0]  lw_fmt  [NLIT] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd4, 3'd4, 3'd0};
  logic        lw_ill  [NLIT] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        lw_illn [NLIT] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  logic [6:0] ops [10] = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011,
                           7'b0110111, 7'b1100011, 7'b1100111, 7'b1101111, 7'b0010011};

  initial begin
    res_t r;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'd0;
    repeat (2) cyc();
    chk("lit_rst_ready", 64'(rdy32), 64'd0);
    chk("lit_rst_valid", 64'(v32), 64'd0);
    rst = 1'b0;
    cyc();
    chk("lit_ready_after_rst", 64'(rdy32), 64'd1);

    // Back-to-back directed stream, one result per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < NLIT; i++) begin
      in_valid = 1'b1;
      in_instr = lw_word[i];
      r = ref_dec(lw_word[i], 64, 1'b1);
      chk("lit_model64", r.imm, lw_i64[i]);
      cyc();
      chk("lit_valid", 64'(v32), 64'd1);
      chk("lit_imm32", 64'(imm32), 64'(lw_i32[i]));
      chk("lit_imm64", imm64, lw_i64[i]);
      chk("lit_fmt", 64'(fmt32), 64'(lw_fmt[i]));
      chk("lit_ill", 64'(ill32), 64'(lw_ill[i]));
      chk("lit_illn", 64'(illn), 64'(lw_illn[i]));
    end
    in_valid = 1'b0;
    cyc();

    // Backpressure: A in O, B in K, C held; then drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = lw_word[0];
    cyc();
    in_instr  = lw_word[1];
    cyc();
    in_instr  = lw_word[2];
    cyc();
    chk("lit_stall_ready", 64'(rdy32), 64'd0);
    chk("lit_stall_imm", 64'(imm32), 64'(lw_i32[0]));
    cyc();
    chk("lit_stall_hold", 64'(imm32), 64'(lw_i32[0]));
    out_ready = 1'b1;
    cyc();
    chk("lit_drain_b", 64'(fmt32), 64'd2);
    chk("lit_drain_b_ready", 64'(rdy32), 64'd1);
    cyc();
    in_valid = 1'b0;
    chk("lit_drain_c", 64'(fmt32), 64'd3);
    cyc();
    chk("lit_drained", 64'(v32), 64'd0);

    // Flush from TWO with input offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = lw_word[3];
    cyc();
    in_instr  = lw_word[4];
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("lit_flush_valid", 64'(v32), 64'd0);
    chk("lit_flush_ready", 64'(rdy32), 64'd1);
    out_ready = 1'b1;
    repeat (2) begin
      cyc();
      chk("lit_flush_gone", 64'(v32), 64'd0);
    end

    // Reset from TWO.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = lw_word[0];
    cyc();
    in_instr  = lw_word[5];
    cyc();
    rst = 1'b1;
    flush = 1'b1;
    cyc();
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("lit_rst2_valid", 64'(v32), 64'd0);
    chk("lit_rst2_imm", imm64, 64'd0);
    out_ready = 1'b1;
    cyc();

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 9)];
      in_instr  = w;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. Accepts one 32-bit instruction per cycle over a valid/ready handshake. Produces the sign-extended XLEN-bit immediate, a format code and an illegal-opcode flag through a registered output stage backed by a one-entry skid buffer. Sits between the fetch/instruction register and the decode/execute pipeline register, and supplies immediates to the ALU operand mux and branch/jump target adders.

## Interface

- XLEN, 32, output immediate width; legal values 32 or 64
- ENABLE_UJ, 1, 1 = decode LUI/AUIPC/JAL/JALR; 0 = flag them illegal

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous pipeline flush; drops all held entries
- in_valid  in  1  in_instr valid
- in_ready  out  1  block can accept in_instr this cycle
- in_instr  in  32  raw instruction word
- out_valid  out  1  out_* fields valid
- out_ready  in  1  consumer accepts out_* this cycle
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  3  0 NONE/R, 1 I, 2 S, 3 B, 4 U, 5 J; 6–7 unused
- out_illegal  out  1  opcode not recognised

## Operation

Decode is combinational on in_instr, keyed by opcode in_instr[6:0]. Every result is sign-extended from in_instr[31] to XLEN.

- 0000011 (load), 1100111 (JALR): I-type, imm = in[31:20].
- 0010011 (OP-IMM): I-type, imm = in[31:20].
  - Exception: funct3 001/101 (shifts) gives a zero-extended shamt.
  - Shamt is in[24:20] when XLEN=32 and in[25:20] when XLEN=64.
  - Bit 30 (SRAI select) is never part of the shamt.
- 0100011: S-type, imm = {in[31:25], in[11:7]}.
- 1100011: B-type, imm = {in[31], in[7], in[30:25], in[11:8], 0}.
- 0110111, 0010111: U-type, imm = {in[31:12], 12'b0}. For XLEN=64, bit 31 sign-extends.
- 1101111: J-type, imm = {in[31], in[19:12], in[20], in[30:21], 0}.
- 0110011: fmt NONE, imm 0, illegal 0.
- Any other opcode: imm 0, fmt NONE, illegal 1. Unknown instructions never pass through.
- ENABLE_UJ=0: opcodes 0110111, 0010111, 1101111 and 1100111 give imm 0, fmt NONE, illegal 1.

Storage is an output register (O) plus a skid register (K), each holding {imm, fmt, illegal} and a valid bit.

- States:
  - EMPTY: O invalid, K invalid.
  - ONE: O valid, K invalid.
  - TWO: O valid, K valid.
- in_ready = !K.valid && !rst.
- out_valid = O.valid. out_* always reflect O.
- Input fire: in_valid && in_ready. Output fire: out_valid && out_ready.
- EMPTY, input fire → ONE (O loads the decode).
- ONE:
  - Input fire and output fire → ONE (O reloads).
  - Input fire only → TWO (K loads).
  - Output fire only → EMPTY.
- TWO:
  - Output fire → ONE (O ← K, K cleared). No input is accepted, since in_ready=0.
- O must not change while out_valid && !out_ready.
- flush, when neither rst nor flush priority is contested: next cycle O and K are invalid (EMPTY). Any input offered in the flush cycle is dropped, even if in_valid && in_ready.
- rst has priority over flush. flush has priority over all handshakes.

## Timing

- Latency: input fire in cycle N → out_valid with that result in cycle N+1.
- Throughput: 1 instruction/cycle while out_ready is held high.
- in_ready deasserts the cycle after K fills. It reasserts the cycle after the output fire that drains K.
- Reset values, visible the cycle after rst is sampled high:
  - out_valid 0, out_imm 0, out_fmt 0, out_illegal 0.
  - in_ready reads 0 while rst is high and 1 after.
- Reset mid-stall (TWO): both entries are discarded and no output fire occurs.
- Simultaneous flush + out_ready in ONE: the entry counts as consumed and the state goes to EMPTY.
- Ordering is strictly FIFO. No entry is duplicated or lost except by flush or rst.

## Test plan

- LW x1,-4(x2), in_instr=0xFFC12083, out_ready=1 → next cycle out_imm=0xFFFFFFFC, out_fmt=1, out_illegal=0.
- SW 0x00512423 → out_imm=0x00000008, fmt 2. BEQ 0xFE000EE3 → out_imm=0xFFFFFFFC, fmt 3. Back-to-back, one result per cycle.
- SRAI 0x4030D093 → out_imm=0x00000003, fmt 1. LUI 0x123450B7 → 0x12345000, fmt 4.
- XLEN=64: LUI 0x800000B7 → 0xFFFFFFFF80000000. Illegal 0x0000007F → imm 0, fmt 0, illegal 1.
- Backpressure: stream instructions A, B, C with out_ready=0 for 3 cycles.
  - A lands in O and B in K; in_ready=0 and C is held.
  - After out_ready=1: A, B, C emerge in order on consecutive cycles, and out_* stay stable while stalled.
- In state TWO, assert flush with in_valid=1 → next cycle out_valid=0 and in_ready=1, and the flushed entries are never output.
- Repeat with rst instead of flush → all out_* zero.
